// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU and memory results through an in-order FIFO into the register file write port.
// It keeps a pending-write scoreboard for hazard queries. Optional ALU bypass when empty: define REG_WB_BYPASS_EN.

module reg_writeback_chk (
  input logic clk,
  input logic reset,
  input logic underflow
);

  // flag a retire to a register that had no outstanding reservation
  always_ff @(posedge clk) begin
    if (!reset && underflow) begin
      $error("reg_writeback: pending counter decremented at zero");
    end
  end

endmodule

module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [2:0]  alu_dest,
  input  logic [31:0] alu_result,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_dest,
  input  logic [31:0] mem_result,
  output logic        mem_ready,
  input  logic        rsv_valid,
  input  logic [2:0]  rsv_dest,
  output logic        rsv_ready,
  input  logic [7:0]  src,
  output logic        hazard,
  output logic        we,
  output logic [2:0]  dest,
  output logic [31:0] result
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0]    DEPTH_C    = CW'(DEPTH);
  localparam logic [CNT_W-1:0] PEND_MAX_C = {CNT_W{1'b1}};

  typedef struct packed {
    logic [2:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t            fifo_r [DEPTH];
  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [CW-1:0]     count_r;
  logic [CNT_W-1:0]  pend_r [8];
  logic [CNT_W-1:0]  pend_nxt_s [8];
  logic              we_r;
  logic [2:0]        dest_r;
  logic [31:0]       result_r;

  logic [CW-1:0]     free_s;
  logic              bypass_s;
  logic              alu_push_s;
  logic              mem_push_s;
  logic              pop_s;
  logic [PTR_W-1:0]  mem_wptr_s;
  logic              rsv_acc_s;
  logic [7:0]        inc_vec_s;
  logic [7:0]        dec_vec_s;
  logic              underflow_s;
  logic              hazard_s;

  // free space is taken from the registered count only, so a same-cycle pop never creates room
  assign free_s    = DEPTH_C - count_r;
  assign alu_ready = (free_s >= CW'(1));
  assign mem_ready = (free_s >= CW'(2));

`ifdef REG_WB_BYPASS_EN
  assign bypass_s = (count_r == CW'(0)) && alu_valid && !mem_valid;
`else
  assign bypass_s = 1'b0;
`endif

  assign alu_push_s = alu_valid && alu_ready && !bypass_s;
  assign mem_push_s = mem_valid && mem_ready;
  assign pop_s      = (count_r != CW'(0));
  assign mem_wptr_s = wptr_r + PTR_W'(alu_push_s);

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= '{dest: 3'd0, data: 32'd0};
      end
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (alu_push_s) begin
        fifo_r[wptr_r] <= '{dest: alu_dest, data: alu_result};
      end
      if (mem_push_s) begin
        fifo_r[mem_wptr_s] <= '{dest: mem_dest, data: mem_result};
      end
      wptr_r  <= wptr_r + PTR_W'(alu_push_s) + PTR_W'(mem_push_s);
      rptr_r  <= rptr_r + PTR_W'(pop_s);
      count_r <= count_r + CW'(alu_push_s) + CW'(mem_push_s) - CW'(pop_s);
    end
  end

  // register file write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r     <= 1'b0;
      dest_r   <= 3'd0;
      result_r <= 32'd0;
    end else if (bypass_s) begin
      we_r     <= 1'b1;
      dest_r   <= alu_dest;
      result_r <= alu_result;
    end else if (pop_s) begin
      we_r     <= 1'b1;
      dest_r   <= fifo_r[rptr_r].dest;
      result_r <= fifo_r[rptr_r].data;
    end else begin
      we_r     <= 1'b0;
    end
  end

  assign we     = we_r;
  assign dest   = dest_r;
  assign result = result_r;

  assign rsv_ready   = (pend_r[rsv_dest] != PEND_MAX_C);
  assign rsv_acc_s   = rsv_valid && rsv_ready;
  assign inc_vec_s   = {7'd0, rsv_acc_s} << rsv_dest;
  assign dec_vec_s   = {7'd0, we_r} << dest_r;
  assign underflow_s = we_r && (pend_r[dest_r] == {CNT_W{1'b0}}) && !inc_vec_s[dest_r];

  // scoreboard next state; a same-register increment and decrement cancel out
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      pend_nxt_s[r] = pend_r[r];
      if (inc_vec_s[r] && !dec_vec_s[r]) begin
        pend_nxt_s[r] = pend_r[r] + CNT_W'(1);
      end else if (dec_vec_s[r] && !inc_vec_s[r] && (pend_r[r] != {CNT_W{1'b0}})) begin
        pend_nxt_s[r] = pend_r[r] - CNT_W'(1);
      end else begin
        pend_nxt_s[r] = pend_r[r];
      end
    end
  end

  // scoreboard state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 8; r++) begin
        pend_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 8; r++) begin
        pend_r[r] <= pend_nxt_s[r];
      end
    end
  end

  // hazard query, decoded like a register file operand read
  always_comb begin
    hazard_s = 1'b0;
    case (src[7:6])
      2'b01:   hazard_s = (pend_r[src[5:3]] != {CNT_W{1'b0}});
      2'b10:   hazard_s = (pend_r[src[5:3]] != {CNT_W{1'b0}}) ||
                          (pend_r[src[2:0]] != {CNT_W{1'b0}});
      default: hazard_s = 1'b0;
    endcase
  end

  assign hazard = hazard_s;

  reg_writeback_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .underflow (underflow_s)
  );

endmodule
